// File: rtl/mod_74x191_4.sv
// 4-bit synchronous up/down counter modelled on the 74x191. It has a parallel load
// and a terminal-count flag (MAXMIN) and a ripple-carry output (RCO) for cascading.
module mod_74x191_4 (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       LOAD,
    input  logic [0:3] D,
    input  logic       EN,
    input  logic       DOWN,
    output logic [0:3] Q,
    output logic       MAXMIN,
    output logic       RCO
);

    logic [0:3] q_q;
    logic [0:3] q_d;

    // Priority is CLR > LOAD > EN > hold. Arithmetic wraps modulo 16.
    always_comb begin
        // NOTE: default first so every path assigns q_d and no latch is inferred.
        q_d = q_q;
        if (CLR) begin
            q_d = 4'd0;
        end else if (LOAD) begin
            q_d = D;
        end else if (EN) begin
            q_d = DOWN ? (q_q - 4'd1) : (q_q + 4'd1);
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking for state so every flop samples pre-edge values.
        q_q <= q_d;
    end

    assign Q      = q_q;
    assign MAXMIN = DOWN ? (q_q == 4'd0) : (q_q == 4'd15);
    assign RCO    = MAXMIN & EN;

endmodule

// File: tb/tb_mod_74x191_4.sv
// Self-checking bench for mod_74x191_4: a table of single-edge vectors, then
// hand-written sequences for full count, async-looking CLR, DOWN changes and an 8-bit cascade.
module tb_mod_74x191_4;

    logic       clk;
    logic       clr, load, en, down;
    logic [3:0] d;
    logic [3:0] q;
    logic       maxmin, rco;

    // Signals for the two-stage cascade
    logic       c_clr, c_load, c_en, c_down;
    logic [3:0] c_d_lo, c_d_hi, c_q_lo, c_q_hi;
    logic       c_mm_lo, c_mm_hi, c_rco_lo, c_rco_hi;

    int n_checks = 0;
    int n_fail   = 0;

    mod_74x191_4 dut (
        .CLK(clk), .CLR(clr), .LOAD(load), .D(d), .EN(en), .DOWN(down),
        .Q(q), .MAXMIN(maxmin), .RCO(rco)
    );

    mod_74x191_4 u_lo (
        .CLK(clk), .CLR(c_clr), .LOAD(c_load), .D(c_d_lo), .EN(c_en), .DOWN(c_down),
        .Q(c_q_lo), .MAXMIN(c_mm_lo), .RCO(c_rco_lo)
    );

    mod_74x191_4 u_hi (
        .CLK(clk), .CLR(c_clr), .LOAD(c_load), .D(c_d_hi), .EN(c_rco_lo), .DOWN(c_down),
        .Q(c_q_hi), .MAXMIN(c_mm_hi), .RCO(c_rco_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       clr;
        logic       load;
        logic [3:0] d;
        logic       en;
        logic       down;
        logic [3:0] exp_q;
        logic       exp_mm;
        logic       exp_rco;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic [3:0] dv,
                         input logic e, input logic dn);
        @(negedge clk);
        clr = c; load = l; d = dv; en = e; down = dn;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b0; load = 1'b0; d = 4'd0; en = 1'b0; down = 1'b0;
        c_clr = 1'b0; c_load = 1'b0; c_en = 1'b0; c_down = 1'b0;
        c_d_lo = 4'd0; c_d_hi = 4'd0;

        //                clr  load d      en   down  q      mm   rco
        vecs.push_back('{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0}); // reset
        vecs.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1}); // reset, mm=DOWN
        vecs.push_back('{1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0}); // load 5
        vecs.push_back('{1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0}); // load beats count
        vecs.push_back('{1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0}); // hold
        vecs.push_back('{1'b0, 1'b0, 4'h3, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0}); // hold
        vecs.push_back('{1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0}); // hold
        vecs.push_back('{1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1}); // load 15 -> max
        vecs.push_back('{1'b1, 1'b1, 4'h3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0}); // CLR beats LOAD on wrap
        vecs.push_back('{1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0}); // load 7
        vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h8, 1'b0, 1'b0}); // up
        vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0}); // down
        vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h8, 1'b0, 1'b0}); // up
        vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0}); // down
        vecs.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1}); // clear, min flag
        vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0}); // 0 wraps to 15
        vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'hE, 1'b0, 1'b0}); // 14

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].load, vecs[i].d, vecs[i].en, vecs[i].down);
            edge_settle();
            check($sformatf("vec%0d_q", i),   {4'h0, q},      {4'h0, vecs[i].exp_q});
            check($sformatf("vec%0d_mm", i),  {7'h0, maxmin}, {7'h0, vecs[i].exp_mm});
            check($sformatf("vec%0d_rco", i), {7'h0, rco},    {7'h0, vecs[i].exp_rco});
        end

        // Full up-count from zero: RCO high only while Q is 15.
        drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        edge_settle();
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            logic [3:0] exp_q;
            exp_q = 4'(i);
            edge_settle();
            check($sformatf("up%0d_q", i),   {4'h0, q},   {4'h0, exp_q});
            check($sformatf("up%0d_rco", i), {7'h0, rco}, {7'h0, (exp_q == 4'hF)});
        end

        // CLR raised between edges leaves Q alone until the next edge.
        drive(1'b0, 1'b1, 4'h9, 1'b0, 1'b0);
        edge_settle();
        @(negedge clk);
        load = 1'b0;
        #2 clr = 1'b1;
        #1 check("clr_between_edges_q", {4'h0, q}, 8'h09);
        edge_settle();
        check("clr_after_edge_q", {4'h0, q}, 8'h00);

        // MAXMIN follows DOWN without a clock edge (Q=0 held, EN=0).
        @(negedge clk);
        clr = 1'b0; en = 1'b0; down = 1'b0;
        #1 check("mm_down0_q0", {7'h0, maxmin}, 8'h00);
        down = 1'b1;
        #1 check("mm_down1_q0", {7'h0, maxmin}, 8'h01);
        en = 1'b1;
        #1 check("rco_down1_q0_en1", {7'h0, rco}, 8'h01);
        en = 1'b0;
        #1 check("rco_en0", {7'h0, rco}, 8'h00);

        // Cascade: 0x0F -> 0x10, then 0xFF -> 0x00 with a single upper RCO pulse.
        @(negedge clk);
        c_clr = 1'b1;
        edge_settle();
        check("cas_reset", {c_q_hi, c_q_lo}, 8'h00);
        @(negedge clk);
        c_clr = 1'b0; c_load = 1'b1; c_d_hi = 4'h0; c_d_lo = 4'hF;
        edge_settle();
        @(negedge clk);
        c_load = 1'b0; c_en = 1'b1;
        edge_settle();
        check("cas_0f_to_10", {c_q_hi, c_q_lo}, 8'h10);
        @(negedge clk);
        c_load = 1'b1; c_en = 1'b0; c_d_hi = 4'hF; c_d_lo = 4'hF;
        edge_settle();
        @(negedge clk);
        c_load = 1'b0; c_en = 1'b1;
        #1 check("cas_hi_rco_pre", {7'h0, c_rco_hi}, 8'h01);
        edge_settle();
        check("cas_ff_to_00", {c_q_hi, c_q_lo}, 8'h00);
        check("cas_hi_rco_post", {7'h0, c_rco_hi}, 8'h00);
        edge_settle();
        check("cas_00_to_01", {c_q_hi, c_q_lo}, 8'h01);
        check("cas_hi_rco_later", {7'h0, c_rco_hi}, 8'h00);

        // Cascade down-count: 0x10 -> 0x0F.
        @(negedge clk);
        c_load = 1'b1; c_en = 1'b0; c_d_hi = 4'h1; c_d_lo = 4'h0;
        edge_settle();
        @(negedge clk);
        c_load = 1'b0; c_en = 1'b1; c_down = 1'b1;
        edge_settle();
        check("cas_10_to_0f", {c_q_hi, c_q_lo}, 8'h0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_74x191_4.md
MOD_74X191_4 -- requirements
Module: mod_74x191_4

Interface
REQ-001: CLK  input  1  sole clock; all state changes on rising edge SHALL occur only here.
REQ-002: CLR  input  1  synchronous active-high reset; SHALL clear the counter on the rising CLK edge where it is sampled high.
REQ-003: LOAD  input  1  active-high synchronous parallel load.
REQ-004: D  input  [0:3]  parallel load data; D[0] MSB, D[3] LSB.
REQ-005: EN  input  1  active-high count enable.
REQ-006: DOWN  input  1  direction select; 0 = count up, 1 = count down.
REQ-007: Q  output  [0:3]  registered count; Q[0] MSB, Q[3] LSB; unsigned 0..15.
REQ-008: MAXMIN  output  1  terminal-count flag, combinational from Q and DOWN.
REQ-009: RCO  output  1  ripple-carry/borrow for cascading, combinational from MAXMIN and EN.

Function
REQ-010: Q SHALL be the only state; it is updated on the CLK rising edge only, with one-cycle latency from sampled inputs.
REQ-011: Per-edge priority SHALL be CLR > LOAD > EN > hold.
REQ-012: CLR=1 -> Q <= 0, regardless of LOAD, EN, DOWN, D.
REQ-013: CLR=0, LOAD=1 -> Q <= D, regardless of EN and DOWN.
REQ-014: CLR=0, LOAD=0, EN=1, DOWN=0 -> Q <= (Q+1) mod 16; 15 wraps to 0.
REQ-015: CLR=0, LOAD=0, EN=1, DOWN=1 -> Q <= (Q-1) mod 16; 0 wraps to 15.
REQ-016: CLR=0, LOAD=0, EN=0 -> Q holds.
REQ-017: Arithmetic SHALL be 4-bit unsigned modulo 16; no carry is stored.
REQ-018: MAXMIN SHALL be 1 when (DOWN=0 and Q=15) or (DOWN=1 and Q=0); otherwise 0.
REQ-019: MAXMIN SHALL follow a DOWN change in the same cycle, with no clock required.
REQ-020: RCO SHALL equal MAXMIN AND EN, so it is high exactly in the cycle before a wrap-around edge, absent CLR/LOAD.
REQ-021: A D value of 15 loaded with DOWN=0 SHALL raise MAXMIN in the cycle after the load edge.
REQ-022: Toggling DOWN mid-count SHALL take effect at the next edge without skipping or repeating a value.
REQ-023: Two instances with the upstream RCO driving the downstream EN SHALL form a correct 8-bit synchronous up/down counter on a shared CLK, CLR and DOWN.
REQ-024: Outputs SHALL carry no X once CLR has been applied for one edge.

Reset
REQ-025: Reset SHALL be synchronous only; asserting CLR between edges SHALL NOT change Q until the next rising edge.
REQ-026: After a CLR edge: Q=0; MAXMIN = DOWN; RCO = DOWN AND EN.
REQ-027: CLR asserted mid-count, including on the wrap edge, SHALL force Q=0 on that edge and override a concurrent LOAD.
REQ-028: Before the first CLR edge, Q is undefined; the bench SHALL apply CLR for at least one edge before checking outputs.

Verification
REQ-029: CLR=1 for 1 edge, then EN=1, DOWN=0 for 16 edges -> Q steps 1,2,...,15,0; RCO=1 only while Q=15.
REQ-030: CLR for 1 edge, then DOWN=1, EN=1 -> Q=15 after the first edge, then 14; MAXMIN=1 while Q=0 before that edge, and 0 after it.
REQ-031: Q=5, LOAD=1, D=4'b1010, EN=1 -> Q=10 (load wins over count); then EN=0 for 3 edges -> Q stays 10.
REQ-032: Q=15, DOWN=0, EN=1, CLR=1 and LOAD=1 on the same edge -> Q=0 (CLR wins); RCO was 1 before that edge.
REQ-033: Q=7, EN=1, toggle DOWN each edge -> Q sequence 8,7,8,7; MAXMIN stays 0.
REQ-034: Two instances cascaded via RCO->EN, DOWN=0 -> combined value 0x0F goes to 0x10 on one edge; 0xFF goes to 0x00 and the upper RCO pulses for one cycle.
